// File: rtl/fir_tap_mul_pkg.sv
// Shared DSP definitions for the FIR tap-multiply stage and the adder tree
// that consumes its products.
//   DSP_DW   : sample width (signed)
//   DSP_CW   : coefficient width (signed)
//   DSP_PW   : full-precision product width, DSP_DW + DSP_CW
//   NTAPS    : number of taps in the delay line
//   CAW      : coefficient address width
package fir_tap_mul_pkg;
   localparam int DSP_DW = 16;
   localparam int DSP_CW = 9;
   localparam int DSP_PW = DSP_DW + DSP_CW;
   localparam int NTAPS  = 8;
   localparam int CAW    = 3;
endpackage

// File: rtl/fir_mul_cell.sv
// One registered signed multiply: p <= a * b at full precision.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears p)
//   en       : load enable; p holds its value while en is low
//   a        : signed DW-bit sample
//   b        : signed CW-bit coefficient
//   p        : signed DW+CW-bit registered product
module fir_mul_cell
   import fir_tap_mul_pkg::*;
#(
   parameter int DW = DSP_DW,
   parameter int CW = DSP_CW,
   localparam int PW = DW + CW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [CW-1:0] b,
   output logic signed [PW-1:0] p
);

   // Both operands are sign-extended to PW before the multiply, so the
   // PW-bit result is the exact product (no truncation is possible).
   always_ff @(posedge clk) begin
      if (rst) begin
         p <= '0;
      end else if (en) begin
         p <= PW'(a) * PW'(b);
      end
   end

endmodule

// File: rtl/fir_tap_mul.sv
// FIR tap-multiply stage: 8-entry sample delay line, 8 writable
// coefficients and 8 registered full-precision products.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : clear taps, fill count and stage-1 valid
//   din_valid, din  : sample strobe (no backpressure) and signed sample
//   coef_we, coef_addr, coef_data : coefficient write port
//   prod_valid      : one-cycle strobe, products for one sample
//   prod0..prod7    : tap[k] * coef[k], held between strobes
// Handshake: din_valid is a pure strobe with no ready; a sample presented
// in cycle n produces prod_valid and its products in cycle n+2, once eight
// samples have been accepted since reset or flush.
module fir_tap_mul
   import fir_tap_mul_pkg::*;
#(
   parameter int DW = DSP_DW,
   parameter int CW = DSP_CW,
   localparam int PW = DW + CW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 din_valid,
   input  logic signed [DW-1:0] din,
   input  logic                 coef_we,
   input  logic [CAW-1:0]       coef_addr,
   input  logic signed [CW-1:0] coef_data,
   output logic                 prod_valid,
   output logic signed [PW-1:0] prod0,
   output logic signed [PW-1:0] prod1,
   output logic signed [PW-1:0] prod2,
   output logic signed [PW-1:0] prod3,
   output logic signed [PW-1:0] prod4,
   output logic signed [PW-1:0] prod5,
   output logic signed [PW-1:0] prod6,
   output logic signed [PW-1:0] prod7
);

   logic signed [DW-1:0] tap  [NTAPS];
   logic signed [CW-1:0] coef [NTAPS];
   logic signed [PW-1:0] prod [NTAPS];
   logic [3:0]           fill_cnt;
   logic                 s1_valid;

   // Delay line, fill counter and stage-1 valid.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int k = 0; k < NTAPS; k++) tap[k] <= '0;
         fill_cnt <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= din_valid;
         if (din_valid) begin
            tap[0] <= din;
            for (int k = 1; k < NTAPS; k++) tap[k] <= tap[k-1];
            if (fill_cnt != 4'(NTAPS)) fill_cnt <= fill_cnt + 4'd1;
         end
      end
   end

   // Coefficients survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
      end else if (coef_we) begin
         coef[coef_addr] <= coef_data;
      end
   end

   // fill_cnt at this point already includes the stage-1 sample, so a
   // full count means the window behind it is complete.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_valid <= 1'b0;
      end else begin
         prod_valid <= s1_valid && (fill_cnt == 4'(NTAPS));
      end
   end

   for (genvar k = 0; k < NTAPS; k++) begin : g_cell
      fir_mul_cell #(
         .DW (DW),
         .CW (CW)
      ) u_cell (
         .clk (clk),
         .rst (rst),
         .en  (s1_valid),
         .a   (tap[k]),
         .b   (coef[k]),
         .p   (prod[k])
      );
   end

   assign prod0 = prod[0];
   assign prod1 = prod[1];
   assign prod2 = prod[2];
   assign prod3 = prod[3];
   assign prod4 = prod[4];
   assign prod5 = prod[5];
   assign prod6 = prod[6];
   assign prod7 = prod[7];

endmodule

// File: tb/tb_fir_tap_mul.sv
module tb_fir_tap_mul;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               din_valid;
   logic signed [15:0] din;
   logic               coef_we;
   logic [2:0]         coef_addr;
   logic signed [8:0]  coef_data;
   logic               prod_valid;
   logic signed [24:0] prod [8];

   int n_cmp = 0;
   int n_err = 0;

   logic [24:0] exp_q[$];

   fir_tap_mul dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .din_valid  (din_valid),
      .din        (din),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .prod_valid (prod_valid),
      .prod0      (prod[0]),
      .prod1      (prod[1]),
      .prod2      (prod[2]),
      .prod3      (prod[3]),
      .prod4      (prod[4]),
      .prod5      (prod[5]),
      .prod6      (prod[6]),
      .prod7      (prod[7])
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic write_coef(input logic [2:0] a, input logic signed [8:0] d);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      tick();
      coef_we = 1'b0;
   endtask

   // Feed samples 1..8 back to back; no strobe may appear until the
   // eighth sample's products arrive two edges after it was presented.
   task automatic prime_run(input string tag);
      for (int i = 1; i <= 8; i++) begin
         din = 16'(i); din_valid = 1'b1;
         tick();
         check({tag, "_nostrobe"}, prod_valid, 0);
      end
      din_valid = 1'b0;
      tick();
      check({tag, "_strobe"}, prod_valid, 1);
   endtask

   // n consecutive samples of one value, then the final strobe edge.
   task automatic stream(input int n, input logic signed [15:0] v);
      for (int i = 0; i < n; i++) begin
         din = v; din_valid = 1'b1;
         tick();
      end
      din_valid = 1'b0;
      tick();
   endtask

   function automatic logic [24:0] model_prod(input logic signed [15:0] t,
                                              input logic signed [8:0] c);
      int r;
      r = int'(t) * int'(c);
      return r[24:0];
   endfunction

   // ---------------- stimulus + checks ----------------
   initial begin
      logic signed [15:0] tap_m [8];
      logic signed [8:0]  coef_m [8];
      logic signed [8:0]  thr_coef [8];
      logic [24:0]        e;
      int                 cnt_m;
      int                 strobes;
      int                 sum;

      rst = 1'b1; flush = 1'b0; din_valid = 1'b0; din = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      check("rst_valid", prod_valid, 0);
      for (int k = 0; k < 8; k++) check($sformatf("rst_prod%0d", k), prod[k], 0);

      // priming with unity coefficients
      for (int k = 0; k < 8; k++) write_coef(3'(k), 9'sd1);
      prime_run("prime");
      sum = 0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("prime_prod%0d", k), prod[k], 8 - k);
         sum += int'(prod[k]);
      end
      check("prime_sum", sum, 36);
      tick();
      check("prime_single", prod_valid, 0);

      // extremes
      for (int k = 0; k < 8; k++) write_coef(3'(k), -9'sd256);
      stream(8, -16'sd32768);
      check("ext_neg_valid", prod_valid, 1);
      for (int k = 0; k < 8; k++) check($sformatf("ext_neg%0d", k), prod[k], 8388608);
      stream(8, 16'sd32767);
      check("ext_pos_valid", prod_valid, 1);
      for (int k = 0; k < 8; k++) check($sformatf("ext_pos%0d", k), prod[k], -8388352);

      // same-cycle coefficient write and sample
      stream(7, 16'sd100);
      din = 16'sd100; din_valid = 1'b1;
      coef_we = 1'b1; coef_addr = 3'd3; coef_data = 9'sd5;
      tick();
      din_valid = 1'b0; coef_we = 1'b0;
      tick();
      check("same_valid", prod_valid, 1);
      check("same_prod3", prod[3], 500);
      check("same_prod0", prod[0], -25600);

      // write during the stage-2 edge affects only the next product
      din = 16'sd100; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      coef_we = 1'b1; coef_addr = 3'd3; coef_data = 9'sd7;
      tick();
      coef_we = 1'b0;
      check("late_valid", prod_valid, 1);
      check("late_prod3_old", prod[3], 500);
      stream(1, 16'sd100);
      check("late_prod3_new", prod[3], 700);

      // flush mid-stream with a same-cycle sample
      flush = 1'b1; din = 16'sd999; din_valid = 1'b1;
      tick();
      flush = 1'b0; din_valid = 1'b0;
      check("flush_valid0", prod_valid, 0);
      tick();
      check("flush_valid1", prod_valid, 0);
      prime_run("flush");
      for (int k = 0; k < 8; k++)
         check($sformatf("flush_prod%0d", k), prod[k], (8 - k) * ((k == 3) ? 7 : -256));

      // reset beats flush, sample and coefficient write
      rst = 1'b1; flush = 1'b1; din = 16'sd55; din_valid = 1'b1;
      coef_we = 1'b1; coef_addr = 3'd2; coef_data = 9'sd9;
      tick();
      rst = 1'b0; flush = 1'b0; din_valid = 1'b0; coef_we = 1'b0;
      check("rstp_valid", prod_valid, 0);
      for (int k = 0; k < 8; k++) check($sformatf("rstp_prod%0d", k), prod[k], 0);
      prime_run("rstp");
      for (int k = 0; k < 8; k++) check($sformatf("rstp_coef%0d", k), prod[k], 0);

      // throughput against a reference model
      thr_coef = '{-9'sd256, 9'sd255, 9'sd3, -9'sd1, 9'sd0, 9'sd100, -9'sd77, 9'sd17};
      for (int k = 0; k < 8; k++) begin
         write_coef(3'(k), thr_coef[k]);
         coef_m[k] = thr_coef[k];
         tap_m[k] = '0;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      cnt_m = 0;
      strobes = 0;
      for (int i = 0; i <= 100; i++) begin
         if (i < 100) begin
            din = 16'($urandom_range(0, 65535)); din_valid = 1'b1;
         end else begin
            din_valid = 1'b0;
         end
         tick();
         if (i < 100) begin
            for (int k = 7; k > 0; k--) tap_m[k] = tap_m[k-1];
            tap_m[0] = din;
            if (cnt_m < 8) cnt_m++;
            if (cnt_m == 8)
               for (int k = 0; k < 8; k++) exp_q.push_back(model_prod(tap_m[k], coef_m[k]));
         end
         // outputs now reflect sample i-1
         check($sformatf("thr_valid%0d", i), prod_valid, (i >= 8) ? 1 : 0);
         if (prod_valid) begin
            strobes++;
            if (exp_q.size() < 8) begin
               check("thr_queue", 0, 1);
            end else begin
               for (int k = 0; k < 8; k++) begin
                  e = exp_q.pop_front();
                  check($sformatf("thr_s%0d_p%0d", i, k), prod[k], $signed(e));
               end
            end
         end
      end
      check("thr_strobes", strobes, 93);
      check("thr_leftover", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fir_tap_mul.md
FIR_TAP_MUL -- requirements
Module: fir_tap_mul

Interface
REQ-001 Parameters SHALL be, one per line:
- DW, 16, sample width (signed two's complement).
- CW, 9, coefficient width (signed two's complement).
- PW = DW+CW, 25, product width; derived, not overridable.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  clear taps and fill count.
- din_valid  in  1  sample strobe; no backpressure.
- din  in  DW  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  3  coefficient index 0..7.
- coef_data  in  CW  signed coefficient.
- prod_valid  out  1  one-cycle strobe marking a product set.
- prod0..prod7  out  PW each  signed products, tap k times coef k, consumed by the 8-input adder tree.

Function
REQ-003 The block SHALL hold an 8-entry tap delay line tap[0..7] of DW bits.
- On an edge with din_valid=1 and flush=0: tap[0] <= din, and tap[k] <= tap[k-1] for k=1..7.
REQ-004 The block SHALL hold 8 coefficient registers coef[0..7].
- On an edge with coef_we=1: coef[coef_addr] <= coef_data.
REQ-005 The block SHALL register a stage-1 valid flag.
- s1_valid <= din_valid AND NOT flush.
REQ-006 Stage 2 SHALL be registered.
- On every edge: prodk <= signed(tap[k]) * signed(coef[k]), using register values from before that edge.
- prod_valid <= s1_valid AND primed.
REQ-007 Latency SHALL be fixed.
- A sample presented in cycle n appears in the products, and prod_valid is high, in cycle n+2.
REQ-008 prod_valid SHALL be high for exactly one cycle per accepted sample once primed.
REQ-009 Products SHALL be full-precision signed PW-bit values, with no truncation or rounding.
- The extreme case -32768 * -256 = +8388608 fits in 25 bits and SHALL be exact.
REQ-010 A fill counter (0..8, saturating) SHALL count accepted samples.
- primed = 1 when the counter, after counting the current sample, equals 8.
REQ-011 flush=1 SHALL, on that edge:
- zero all taps, the fill counter and s1_valid;
- discard a same-cycle din_valid sample.
- Coefficients SHALL be unaffected.
REQ-012 A coefficient write and a sample in the same cycle SHALL both take effect on that edge.
- The product for that sample (computed on the next edge) SHALL use the new coefficient.
REQ-013 A coefficient write to an address in the cycle where stage 2 computes SHALL NOT affect that product; it affects the next product.
REQ-014 prod0..prod7 SHALL hold their last value between strobes.
- prod_valid=0 marks them don't-care for the consumer.
REQ-015 Back-to-back din_valid on every cycle SHALL be sustained at full throughput, with no gaps in prod_valid.

Reset
REQ-016 rst=1 SHALL, on the edge, zero:
- taps, coefficients, fill counter, s1_valid;
- prod_valid and prod0..prod7.
REQ-017 rst SHALL take priority over flush, din_valid and coef_we in the same cycle.
REQ-018 Reset asserted mid-stream SHALL suppress any in-flight prod_valid.
- At least 8 new samples SHALL be needed before the next strobe.

Structure
REQ-019 A shared DSP package SHALL hold: DW, CW, PW, the tap count 8, and the coefficient address width 3.
- The adder-tree stage SHALL use the same PW.
REQ-020 One sub-module, fir_mul_cell, SHALL implement one registered signed DW x CW multiply.
- It SHALL be instantiated 8 times.
REQ-021 No other sub-modules; no combinational path from inputs to outputs.

Verification
REQ-022 Directed scenarios the bench SHALL cover:
- Priming: coef[k]=1 for all k; feed samples 1..8 on consecutive cycles -> no prod_valid for samples 1..7; the strobe for sample 8 gives prod0..prod7 = 8,7,...,1 exactly two cycles after sample 8; adder output equals 36 in its upper bits per its scaling.
- Extremes: all coef=-256, all samples -32768 -> every prod = +8388608 (25'h0800000); all samples +32767 -> every prod = -8388352.
- Same-cycle update: coef_we to addr 3 with value 5, alongside a sample of value 100, primed -> prod3=500 on the next strobe; the previous coef value is never used for that sample.
- Flush mid-stream: primed, flush together with din_valid -> that sample is dropped, taps are zero, prod_valid stays low until 8 further samples, and coefficients are retained.
- Reset priority: rst, flush, din_valid and coef_we all asserted -> every output is 0 on the next cycle, coef[all]=0, and no strobe occurs for the following 9 cycles of samples until 8 are accepted.
- Throughput: 100 continuous samples -> 93 strobes on consecutive cycles, each matching a reference model of the 8-tap products.
